// File: rtl/traffic_light_ctrl_multi.sv
// Round-robin N-way traffic light controller with latched pedestrian requests and an all-red WALK phase.
// Defining TL_FLASH_MODE_EN adds a flash_mode input that forces all-yellow flashing.
module traffic_light_ctrl_multi #(
  parameter int N_DIR         = 4,
  parameter int CNT_W         = 16,
  parameter int GREEN_CYC     = 20,
  parameter int MIN_GREEN_CYC = 8,
  parameter int YELLOW_CYC    = 4,
  parameter int ALLRED_CYC    = 2,
  parameter int PED_CYC       = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_DIR-1:0]           btn,
`ifdef TL_FLASH_MODE_EN
  input  logic                       flash_mode,
`endif
  output logic [3*N_DIR-1:0]         lights,
  output logic [N_DIR-1:0]           walk,
  output logic [N_DIR-1:0]           ped_pending,
  output logic [1:0]                 state,
  output logic [$clog2(N_DIR)-1:0]   dir
);

  localparam int DIR_W = $clog2(N_DIR);

  localparam logic [1:0] ST_ALL_RED = 2'd0;
  localparam logic [1:0] ST_GREEN   = 2'd1;
  localparam logic [1:0] ST_YELLOW  = 2'd2;
  localparam logic [1:0] ST_WALK    = 2'd3;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] T_PED    = CNT_W'(PED_CYC - 1);
  // Timer value on the last cycle of a minimum-length green.
  localparam logic [CNT_W-1:0] T_EARLY  = CNT_W'(GREEN_CYC - MIN_GREEN_CYC);

  logic [1:0]           state_reg, state_next;
  logic [DIR_W-1:0]     dir_reg, dir_next;
  logic [CNT_W-1:0]     timer_reg, timer_next;
  logic [3*N_DIR-1:0]   lights_reg, lights_next, lamp_next;
  logic [N_DIR-1:0]     walk_reg, walk_next;
  logic [N_DIR-1:0]     ped_reg, ped_next;
  logic [N_DIR-1:0]     btn_s1_reg, btn_s2_reg, btn_s3_reg;
  logic [N_DIR-1:0]     btn_rise;
  logic [DIR_W-1:0]     dir_wrap;
  logic                 timer_zero;

`ifdef TL_FLASH_MODE_EN
  logic flash_s1_reg, flash_s2_reg;
  logic flash_active_reg, flash_active_next;
  logic flash_yellow_reg, flash_yellow_next;
`endif

  assign btn_rise   = btn_s2_reg & ~btn_s3_reg;
  assign timer_zero = (timer_reg == '0);
  assign dir_wrap   = (dir_reg == DIR_W'(N_DIR - 1)) ? '0 : dir_reg + DIR_W'(1);

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    timer_next = timer_reg - CNT_W'(1);
    walk_next  = walk_reg;
    ped_next   = ped_reg | btn_rise;
    case (state_reg)
      ST_ALL_RED: begin
        if (timer_zero) begin
          if (|ped_reg) begin
            state_next = ST_WALK;
            timer_next = T_PED;
            walk_next  = ped_reg;
            // A request detected on this very cycle survives the clear.
            ped_next   = btn_rise;
          end else begin
            state_next = ST_GREEN;
            timer_next = T_GREEN;
          end
        end
      end
      ST_GREEN: begin
        if (timer_zero || ((|ped_reg) && (timer_reg <= T_EARLY))) begin
          state_next = ST_YELLOW;
          timer_next = T_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer_zero) begin
          state_next = ST_ALL_RED;
          timer_next = T_ALLRED;
          dir_next   = dir_wrap;
        end
      end
      default: begin
        if (timer_zero) begin
          state_next = ST_GREEN;
          timer_next = T_GREEN;
          walk_next  = '0;
        end
      end
    endcase
`ifdef TL_FLASH_MODE_EN
    flash_active_next = flash_s2_reg;
    flash_yellow_next = flash_yellow_reg;
    if (flash_s2_reg) begin
      state_next = ST_YELLOW;
      dir_next   = dir_reg;
      walk_next  = '0;
      ped_next   = ped_reg;
      if (!flash_active_reg || timer_zero) begin
        flash_yellow_next = !flash_active_reg || !flash_yellow_reg;
        timer_next        = T_YELLOW;
      end else begin
        timer_next = timer_reg - CNT_W'(1);
      end
    end else if (flash_active_reg) begin
      state_next = ST_ALL_RED;
      dir_next   = '0;
      timer_next = T_ALLRED;
      walk_next  = '0;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIR; gi++) begin : g_lamp
      assign lamp_next[3*gi +: 3] = (dir_next != DIR_W'(gi)) ? LAMP_RED :
                                    (state_next == ST_GREEN)  ? LAMP_GREEN :
                                    (state_next == ST_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    end
  endgenerate

`ifdef TL_FLASH_MODE_EN
  assign lights_next = !flash_active_next ? lamp_next :
                       flash_yellow_next  ? {N_DIR{LAMP_YELLOW}} : {N_DIR{LAMP_RED}};
`else
  assign lights_next = lamp_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_ALL_RED;
      dir_reg    <= '0;
      timer_reg  <= T_ALLRED;
      lights_reg <= {N_DIR{LAMP_RED}};
      walk_reg   <= '0;
      ped_reg    <= '0;
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
      btn_s3_reg <= '0;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      timer_reg  <= timer_next;
      lights_reg <= lights_next;
      walk_reg   <= walk_next;
      ped_reg    <= ped_next;
      btn_s1_reg <= btn;
      btn_s2_reg <= btn_s1_reg;
      btn_s3_reg <= btn_s2_reg;
    end
  end

`ifdef TL_FLASH_MODE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_s1_reg     <= 1'b0;
      flash_s2_reg     <= 1'b0;
      flash_active_reg <= 1'b0;
      flash_yellow_reg <= 1'b0;
    end else begin
      flash_s1_reg     <= flash_mode;
      flash_s2_reg     <= flash_s1_reg;
      flash_active_reg <= flash_active_next;
      flash_yellow_reg <= flash_yellow_next;
    end
  end
`endif

  assign lights      = lights_reg;
  assign walk        = walk_reg;
  assign ped_pending = ped_reg;
  assign state       = state_reg;
  assign dir         = dir_reg;

endmodule
